// File: rtl/umi_regdev.sv
// UMI request/response endpoint bridging to a simple register port.
//
// A UMI request of up to NREG register-width lanes is accepted in idle, split
// into one register access per lane, and answered with a single UMI response
// (reads and writes) or silently retired (posted writes). Requests that do not
// fit the register port get an error response without touching the registers.
//
// Ports:
//   clk, nreset              clock, asynchronous active-low reset
//   udev_req_*               UMI request channel (valid/ready)
//   udev_resp_*              UMI response channel (valid/ready)
//   reg_valid/write/addr/    register request (valid/ready)
//   wdata/prot/ready
//   reg_rvalid/rdata/err     register read return; reg_err also qualifies writes
module umi_regdev #(
  parameter int unsigned RW        = 32,
  parameter int unsigned RAW       = 32,
  parameter int unsigned GRPOFFSET = 24,
  parameter int unsigned GRPAW     = 0,
  parameter int unsigned GRPID     = 0,
  parameter int unsigned CW        = 32,
  parameter int unsigned AW        = 64,
  parameter int unsigned DW        = 64
) (
  input  logic           clk,
  input  logic           nreset,
  // UMI request
  input  logic           udev_req_valid,
  input  logic [CW-1:0]  udev_req_cmd,
  input  logic [AW-1:0]  udev_req_dstaddr,
  input  logic [AW-1:0]  udev_req_srcaddr,
  input  logic [DW-1:0]  udev_req_data,
  output logic           udev_req_ready,
  // UMI response
  output logic           udev_resp_valid,
  output logic [CW-1:0]  udev_resp_cmd,
  output logic [AW-1:0]  udev_resp_dstaddr,
  output logic [AW-1:0]  udev_resp_srcaddr,
  output logic [DW-1:0]  udev_resp_data,
  input  logic           udev_resp_ready,
  // Register port
  output logic           reg_valid,
  output logic           reg_write,
  output logic [RAW-1:0] reg_addr,
  output logic [RW-1:0]  reg_wdata,
  output logic [1:0]     reg_prot,
  input  logic           reg_ready,
  input  logic           reg_rvalid,
  input  logic [RW-1:0]  reg_rdata,
  input  logic [1:0]     reg_err
);

  localparam int unsigned NREG = DW / RW;
  localparam int unsigned BW   = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [4:0] OpReqRead   = 5'h01;
  localparam logic [4:0] OpReqWrite  = 5'h03;
  localparam logic [4:0] OpReqPosted = 5'h05;
  localparam logic [4:0] OpRespRead  = 5'h02;
  localparam logic [4:0] OpRespWrite = 5'h04;

  typedef enum logic [1:0] {StIdle, StAcc, StRdWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            init_q;
  logic [BW-1:0]   beat_q, beat_d;
  logic [1:0]      err_q, err_d;
  logic [CW-1:0]   cmd_q;
  logic [AW-1:0]   dst_q, src_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            accept;
  logic [4:0]      opcode;
  logic [2:0]      size;
  logic [7:0]      len;
  logic            is_read, is_write, is_posted;
  logic            size_ok, len_ok, grp_ok, legal, last_beat;
  logic [RW-1:0]   lane_wdata;

  assign accept    = udev_req_valid & udev_req_ready;
  assign opcode    = cmd_q[4:0];
  assign size      = cmd_q[7:5];
  assign len       = cmd_q[15:8];
  assign is_read   = (opcode == OpReqRead);
  assign is_write  = (opcode == OpReqWrite);
  assign is_posted = (opcode == OpReqPosted);
  assign size_ok   = ((32'd8 << size) == RW);
  assign len_ok    = (32'(len) < NREG);
  assign legal     = (is_read | is_write | is_posted) & grp_ok & size_ok & len_ok;
  assign last_beat = (32'(beat_q) == 32'(len));

  if (GRPAW == 0) begin : g_nogrp
    assign grp_ok = 1'b1;
  end else begin : g_grp
    assign grp_ok = (dst_q[GRPOFFSET +: GRPAW] == GRPAW'(GRPID));
  end

  always_comb begin
    lane_wdata = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(beat_q) == i) lane_wdata = data_q[i*RW +: RW];
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAcc;
          beat_d  = '0;
          err_d   = '0;
          rdata_d = '0;
        end
      end
      StAcc: begin
        if (!legal) begin
          // Only reads and writes expect an answer; everything else is dropped.
          if (is_read || is_write) begin
            state_d = StResp;
            err_d   = 2'b10;
          end else begin
            state_d = StIdle;
          end
        end else if (reg_ready) begin
          if (is_read) begin
            state_d = StRdWait;
          end else begin
            err_d  = err_q | reg_err;
            beat_d = beat_q + BW'(1);
            if (last_beat) state_d = is_posted ? StIdle : StResp;
          end
        end
      end
      StRdWait: begin
        if (reg_rvalid) begin
          for (int unsigned i = 0; i < NREG; i++) begin
            if (32'(beat_q) == i) rdata_d[i*RW +: RW] = reg_rdata;
          end
          err_d   = err_q | reg_err;
          beat_d  = beat_q + BW'(1);
          state_d = last_beat ? StResp : StAcc;
        end
      end
      StResp: begin
        if (udev_resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
      beat_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      // Holds ready low until the first edge after reset release.
      init_q  <= 1'b1;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Request and response payload carry no reset; state alone gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q  <= udev_req_cmd;
      dst_q  <= udev_req_dstaddr;
      src_q  <= udev_req_srcaddr;
      data_q <= udev_req_data;
    end
    rdata_q <= rdata_d;
  end

  assign udev_req_ready = init_q & (state_q == StIdle);

  assign reg_valid = (state_q == StAcc) & legal;
  assign reg_write = reg_valid & ~is_read;
  assign reg_addr  = dst_q[RAW-1:0] + RAW'(32'(beat_q) * (RW / 8));
  assign reg_wdata = lane_wdata;
  assign reg_prot  = cmd_q[21:20];

  assign udev_resp_valid   = (state_q == StResp);
  assign udev_resp_dstaddr = src_q;
  assign udev_resp_srcaddr = dst_q;
  // Cleared on accept and only filled by read returns, so writes answer zero.
  assign udev_resp_data    = rdata_q;

  always_comb begin
    udev_resp_cmd        = cmd_q;
    udev_resp_cmd[4:0]   = is_read ? OpRespRead : OpRespWrite;
    udev_resp_cmd[26:25] = err_q;
  end

endmodule

// File: tb/tb_umi_regdev.sv
// Self-checking bench for umi_regdev: directed vector table, hand-written
// timing/reset sequences, then randomized traffic against a reference model.
module tb_umi_regdev;

  localparam int unsigned RW  = 32;
  localparam int unsigned RAW = 24;
  localparam int unsigned CW  = 32;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;

  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic           udev_req_valid = 1'b0;
  logic [CW-1:0]  udev_req_cmd = '0;
  logic [AW-1:0]  udev_req_dstaddr = '0;
  logic [AW-1:0]  udev_req_srcaddr = '0;
  logic [DW-1:0]  udev_req_data = '0;
  logic           udev_req_ready;
  logic           udev_resp_valid;
  logic [CW-1:0]  udev_resp_cmd;
  logic [AW-1:0]  udev_resp_dstaddr;
  logic [AW-1:0]  udev_resp_srcaddr;
  logic [DW-1:0]  udev_resp_data;
  logic           udev_resp_ready = 1'b0;
  logic           reg_valid;
  logic           reg_write;
  logic [RAW-1:0] reg_addr;
  logic [RW-1:0]  reg_wdata;
  logic [1:0]     reg_prot;
  logic           reg_ready = 1'b0;
  logic           reg_rvalid = 1'b0;
  logic [RW-1:0]  reg_rdata = '0;
  logic [1:0]     reg_err = '0;

  umi_regdev #(
    .RW(RW), .RAW(RAW), .GRPOFFSET(24), .GRPAW(8), .GRPID(32'h5A),
    .CW(CW), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .nreset(nreset),
    .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
    .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
    .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
    .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
    .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
    .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_prot(reg_prot), .reg_ready(reg_ready),
    .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-side model: logs every access, answers reads after a latency.
  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [1:0]  prot;
    logic [1:0]  err;
    logic [31:0] rdata;
  } acc_t;

  acc_t        log_q[$];
  logic [1:0]  err_src_q[$];
  logic [31:0] rd_src_q[$];
  acc_t        acc_rec;
  bit          rand_mode = 1'b0;
  int          ready_pct = 100;
  int          rd_lat = 3;
  int          cnt = 0;
  logic [31:0] pend_rdata;
  logic [1:0]  pend_err;

  initial begin
    forever begin
      @(negedge clk);
      reg_rvalid = 1'b0;
      reg_err    = 2'b00;
      reg_rdata  = rand_mode ? $urandom : 32'h0;
      if (!nreset) begin
        cnt       = 0;
        reg_ready = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            reg_rvalid = 1'b1;
            reg_rdata  = pend_rdata;
            reg_err    = pend_err;
          end
        end else if (rand_mode && $urandom_range(0, 9) == 0) begin
          // Stray return while no read is outstanding; must be ignored.
          reg_rvalid = 1'b1;
          reg_err    = 2'b11;
        end
        reg_ready = ($urandom_range(1, 100) <= ready_pct);
        if (reg_valid && reg_ready) begin
          acc_rec.wr    = reg_write;
          acc_rec.addr  = reg_addr;
          acc_rec.wdata = reg_wdata;
          acc_rec.prot  = reg_prot;
          if (err_src_q.size() > 0) acc_rec.err = err_src_q.pop_front();
          else if (rand_mode && $urandom_range(0, 7) == 0) acc_rec.err = 2'($urandom_range(1, 3));
          else acc_rec.err = 2'b00;
          if (rd_src_q.size() > 0) acc_rec.rdata = rd_src_q.pop_front();
          else acc_rec.rdata = $urandom;
          if (acc_rec.wr) begin
            reg_err = acc_rec.err;
          end else begin
            pend_rdata = acc_rec.rdata;
            pend_err   = acc_rec.err;
            cnt        = rand_mode ? $urandom_range(1, 4) : rd_lat;
          end
          log_q.push_back(acc_rec);
        end
      end
    end
  end

  function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size,
                                         input logic [7:0] len, input logic [1:0] prot);
    logic [31:0] c;
    c = '0;
    c[4:0]   = op;
    c[7:5]   = size;
    c[15:8]  = len;
    c[21:20] = prot;
    return c;
  endfunction

  task automatic drive_req(input logic [31:0] cmd, input logic [63:0] dst,
                           input logic [63:0] src, input logic [63:0] data);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    udev_req_valid   = 1'b1;
    udev_req_cmd     = cmd;
    udev_req_dstaddr = dst;
    udev_req_srcaddr = src;
    udev_req_data    = data;
    for (int i = 0; i < 50; i++) begin
      if (udev_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    udev_req_valid = 1'b0;
    check("req_accepted", ok, 1);
  endtask

  task automatic run_txn(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src,
                         input logic [63:0] data, input int hold, output bit got,
                         output logic [31:0] rcmd, output logic [63:0] rdst,
                         output logic [63:0] rsrc, output logic [63:0] rdat);
    bit done;
    done = 1'b0;
    got  = 1'b0;
    rcmd = '0;
    rdst = '0;
    rsrc = '0;
    rdat = '0;
    log_q.delete();
    drive_req(cmd, dst, src, data);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (udev_resp_valid) begin
        got  = 1'b1;
        done = 1'b1;
        rcmd = udev_resp_cmd;
        rdst = udev_resp_dstaddr;
        rsrc = udev_resp_srcaddr;
        rdat = udev_resp_data;
      end else if (udev_req_ready) begin
        done = 1'b1;
      end
    end
    check("txn_done", done, 1);
    if (got) begin
      repeat (hold) @(negedge clk);
      udev_resp_ready = 1'b1;
      @(posedge clk);
      #1;
      udev_resp_ready = 1'b0;
    end
  endtask

  // Reference model: derives the expected access list and response from the
  // request fields and what the register side returned.
  task automatic model_check(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src,
                             input logic [63:0] data, input bit got, input logic [31:0] rcmd,
                             input logic [63:0] rdst, input logic [63:0] rsrc,
                             input logic [63:0] rdat);
    logic [4:0]  op;
    int          len;
    int          n;
    bit          legal;
    bit          respond;
    logic [1:0]  err;
    logic [31:0] ecmd;
    logic [63:0] edata;
    logic [23:0] ea;
    op      = cmd[4:0];
    len     = int'(cmd[15:8]);
    legal   = (op == 5'h01 || op == 5'h03 || op == 5'h05) && dst[31:24] == 8'h5A &&
              cmd[7:5] == 3'd2 && len <= 1;
    respond = (op == 5'h01 || op == 5'h03);
    n       = legal ? len + 1 : 0;
    check("access_count", log_q.size(), n);
    err   = legal ? 2'b00 : 2'b10;
    edata = '0;
    for (int b = 0; b < n && b < log_q.size(); b++) begin
      ea = dst[23:0] + 24'(b * 4);
      check("access", {log_q[b].wr, log_q[b].prot, log_q[b].addr, log_q[b].wdata},
            {op != 5'h01, cmd[21:20], ea, data[b*32 +: 32]});
      err = err | log_q[b].err;
      edata[b*32 +: 32] = log_q[b].rdata;
    end
    if (op != 5'h01 || !legal) edata = '0;
    check("resp_present", got, respond);
    if (got && respond) begin
      ecmd        = cmd;
      ecmd[4:0]   = (op == 5'h01) ? 5'h02 : 5'h04;
      ecmd[26:25] = err;
      check("resp_cmd", rcmd, ecmd);
      check("resp_dst", rdst, src);
      check("resp_src", rsrc, dst);
      check("resp_data", rdat, edata);
    end
  endtask

  typedef struct {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] data;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  err0;
    int          nacc;
    bit          resp;
    logic [1:0]  err;
    logic [63:0] rdata;
    logic [23:0] addr0;
  } vec_t;

  vec_t vt[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    bit          seen;
    logic [31:0] rcmd;
    logic [31:0] cmd;
    logic [31:0] ecmd;
    logic [63:0] rdst, rsrc, rdat, dst, src, data;
    logic [7:0]  grp;

    vt[0]  = '{mk_cmd(5'h03, 3'd2, 8'd0, 2'b00), 64'h5A00_0010, 64'h0000_0000_AABB_CCDD,
               32'h0, 32'h0, 2'b00, 1, 1'b1, 2'b00, 64'h0, 24'h000010};
    vt[1]  = '{mk_cmd(5'h01, 3'd2, 8'd1, 2'b01), 64'h5A00_0020, 64'h0,
               32'h1111_1111, 32'h2222_2222, 2'b00, 2, 1'b1, 2'b00, 64'h2222_2222_1111_1111,
               24'h000020};
    vt[2]  = '{mk_cmd(5'h05, 3'd2, 8'd1, 2'b10), 64'h5A00_0040, 64'h0123_4567_89AB_CDEF,
               32'h0, 32'h0, 2'b00, 2, 1'b0, 2'b00, 64'h0, 24'h000040};
    vt[3]  = '{mk_cmd(5'h03, 3'd2, 8'd0, 2'b00), 64'h5A00_0014, 64'h0000_0000_DEAD_BEEF,
               32'h0, 32'h0, 2'b01, 1, 1'b1, 2'b01, 64'h0, 24'h000014};
    vt[4]  = '{mk_cmd(5'h01, 3'd3, 8'd0, 2'b00), 64'h5A00_0020, 64'h0,
               32'h0, 32'h0, 2'b00, 0, 1'b1, 2'b10, 64'h0, 24'h0};
    vt[5]  = '{mk_cmd(5'h01, 3'd2, 8'd2, 2'b00), 64'h5A00_0020, 64'h0,
               32'h0, 32'h0, 2'b00, 0, 1'b1, 2'b10, 64'h0, 24'h0};
    vt[6]  = '{mk_cmd(5'h09, 3'd2, 8'd0, 2'b00), 64'h5A00_0020, 64'h0,
               32'h0, 32'h0, 2'b00, 0, 1'b0, 2'b00, 64'h0, 24'h0};
    vt[7]  = '{mk_cmd(5'h01, 3'd2, 8'd0, 2'b11), 64'hFFFF_0000_5A00_0030, 64'h0,
               32'hCAFE_F00D, 32'h0, 2'b00, 1, 1'b1, 2'b00, 64'h0000_0000_CAFE_F00D, 24'h000030};
    vt[8]  = '{mk_cmd(5'h01, 3'd2, 8'd0, 2'b00), 64'h5B00_0030, 64'h0,
               32'h0, 32'h0, 2'b00, 0, 1'b1, 2'b10, 64'h0, 24'h0};
    vt[9]  = '{mk_cmd(5'h05, 3'd1, 8'd0, 2'b00), 64'h5A00_0030, 64'h0,
               32'h0, 32'h0, 2'b00, 0, 1'b0, 2'b00, 64'h0, 24'h0};
    vt[10] = '{mk_cmd(5'h03, 3'd2, 8'd1, 2'b00), 64'h5AFF_FFFC, 64'h5555_5555_6666_6666,
               32'h0, 32'h0, 2'b10, 2, 1'b1, 2'b10, 64'h0, 24'hFFFFFC};
    vt[11] = '{mk_cmd(5'h02, 3'd2, 8'd0, 2'b00), 64'h5A00_0010, 64'h0,
               32'h0, 32'h0, 2'b00, 0, 1'b0, 2'b00, 64'h0, 24'h0};

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("rst_outputs", {udev_req_ready, udev_resp_valid, reg_valid, reg_write}, 4'b0000);
    #2 nreset = 1'b1;
    #1 check("rst_ready_before_edge", udev_req_ready, 0);
    @(negedge clk);
    check("rst_ready_after_edge", udev_req_ready, 1);

    // Minimum latency single write
    log_q.delete();
    @(negedge clk);
    udev_req_valid   = 1'b1;
    udev_req_cmd     = mk_cmd(5'h03, 3'd2, 8'd0, 2'b00);
    udev_req_dstaddr = 64'h5A00_0010;
    udev_req_srcaddr = 64'h77;
    udev_req_data    = 64'h0000_0000_AABB_CCDD;
    check("lat_ready_c0", udev_req_ready, 1);
    @(posedge clk);
    #1 udev_req_valid = 1'b0;
    @(negedge clk);
    check("lat_regwr_c1", {reg_valid, reg_write, reg_addr, reg_wdata},
          {1'b1, 1'b1, 24'h000010, 32'hAABB_CCDD});
    @(negedge clk);
    check("lat_resp_c2", {udev_resp_valid, udev_resp_cmd[4:0], udev_resp_cmd[26:25]},
          {1'b1, 5'h04, 2'b00});
    udev_resp_ready = 1'b1;
    @(posedge clk);
    #1 udev_resp_ready = 1'b0;
    check("lat_single_access", log_q.size(), 1);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      rd_src_q.delete();
      err_src_q.delete();
      rd_src_q.push_back(vt[i].rd0);
      rd_src_q.push_back(vt[i].rd1);
      err_src_q.push_back(vt[i].err0);
      src = 64'h0000_0001_0000_0100 + 64'(i);
      run_txn(vt[i].cmd, vt[i].dst, src, vt[i].data, 0, got, rcmd, rdst, rsrc, rdat);
      check($sformatf("tv%0d_nacc", i), log_q.size(), vt[i].nacc);
      check($sformatf("tv%0d_resp", i), got, vt[i].resp);
      if (vt[i].resp)
        check($sformatf("tv%0d_err_data", i), {rcmd[26:25], rdat}, {vt[i].err, vt[i].rdata});
      if (vt[i].nacc > 0 && log_q.size() > 0)
        check($sformatf("tv%0d_addr0", i), log_q[0].addr, vt[i].addr0);
      model_check(vt[i].cmd, vt[i].dst, src, vt[i].data, got, rcmd, rdst, rsrc, rdat);
    end
    rd_src_q.delete();
    err_src_q.delete();

    // Response held under back-pressure
    rd_lat = 2;
    rd_src_q.push_back(32'h1234_5678);
    cmd = mk_cmd(5'h01, 3'd2, 8'd0, 2'b11);
    drive_req(cmd, 64'h5A00_0044, 64'hABCD, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (udev_resp_valid) seen = 1'b1;
    end
    check("hold_resp_seen", seen, 1);
    ecmd        = cmd;
    ecmd[4:0]   = 5'h02;
    ecmd[26:25] = 2'b00;
    for (int k = 0; k < 5; k++) begin
      check("hold_stable", {udev_resp_valid, udev_req_ready, udev_resp_cmd, udev_resp_data,
                            udev_resp_dstaddr},
            {1'b1, 1'b0, ecmd, 64'h0000_0000_1234_5678, 64'hABCD});
      @(negedge clk);
    end
    udev_resp_ready = 1'b1;
    @(posedge clk);
    #1 udev_resp_ready = 1'b0;

    // Reset while waiting for read data
    rd_lat = 10;
    log_q.delete();
    drive_req(mk_cmd(5'h01, 3'd2, 8'd0, 2'b00), 64'h5A00_0050, 64'h1, 64'h0);
    repeat (3) @(negedge clk);
    #2 nreset = 1'b0;
    #1 check("rst_mid_outputs", {reg_valid, reg_write, udev_resp_valid, udev_req_ready}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    #2 nreset = 1'b1;
    #1 check("rst_mid_ready_before_edge", udev_req_ready, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (udev_resp_valid) seen = 1'b1;
    end
    check("rst_mid_no_resp", seen, 0);
    check("rst_mid_accesses", log_q.size(), 1);
    check("rst_mid_idle", udev_req_ready, 1);
    rd_lat = 3;

    // Randomized traffic against the model
    rand_mode = 1'b1;
    ready_pct = 60;
    for (int t = 0; t < 150; t++) begin
      cmd = $urandom;
      case ($urandom_range(0, 7))
        0, 1:    cmd[4:0] = 5'h01;
        2, 3:    cmd[4:0] = 5'h03;
        4:       cmd[4:0] = 5'h05;
        5:       cmd[4:0] = 5'h09;
        6:       cmd[4:0] = 5'h02;
        default: cmd[4:0] = 5'($urandom);
      endcase
      cmd[7:5]  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd2;
      cmd[15:8] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
      dst       = {$urandom, $urandom};
      grp       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h5A;
      dst[31:24] = grp;
      src       = {$urandom, $urandom};
      data      = {$urandom, $urandom};
      run_txn(cmd, dst, src, data, $urandom_range(0, 2), got, rcmd, rdst, rsrc, rdat);
      model_check(cmd, dst, src, data, got, rcmd, rdst, rsrc, rdat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/umi_regdev.md
UMI_REGDEV -- requirements
Module: umi_regdev

Interface
REQ-001 SHALL have parameter RW, default 32, meaning register data width; RW SHALL be 8, 16, 32 or 64 and RW<=DW.
REQ-002 SHALL have parameter RAW, default 32, meaning register address width; RAW<=AW.
REQ-003 SHALL have parameters GRPOFFSET, GRPAW and GRPID, defaults 24, 0 and 0, meaning the group-match field dstaddr[GRPOFFSET+:GRPAW]==GRPID; GRPAW=0 disables the match (always true).
REQ-004 SHALL have parameters CW, AW and DW, defaults 32, 64 and 64, meaning the UMI command, address and data widths; NREG=DW/RW is the number of lanes per request.
REQ-005 SHALL have the ports clk, input, 1 bit, clock; and nreset, input, 1 bit, reset. Reset is asynchronous and active-low.
REQ-006 SHALL have the request ports udev_req_valid (in, 1), udev_req_cmd (in, CW), udev_req_dstaddr (in, AW), udev_req_srcaddr (in, AW), udev_req_data (in, DW) and udev_req_ready (out, 1).
REQ-007 SHALL have the response ports udev_resp_valid (out, 1), udev_resp_cmd (out, CW), udev_resp_dstaddr (out, AW), udev_resp_srcaddr (out, AW), udev_resp_data (out, DW) and udev_resp_ready (in, 1).
REQ-008 SHALL have the register ports reg_valid (out, 1), reg_write (out, 1), reg_addr (out, RAW), reg_wdata (out, RW), reg_prot (out, 2), reg_ready (in, 1), reg_rvalid (in, 1), reg_rdata (in, RW) and reg_err (in, 2).

Function
REQ-009 Command fields SHALL be: opcode=cmd[4:0] (REQ_READ 5'h01, REQ_WRITE 5'h03, REQ_POSTED 5'h05, RESP_READ 5'h02, RESP_WRITE 5'h04), SIZE=cmd[7:5], LEN=cmd[15:8], PROT=cmd[21:20], ERR=cmd[26:25].
REQ-010 FSM states SHALL be IDLE, ACC, RDWAIT and RESP; udev_req_ready=1 only in IDLE.
REQ-011 On a handshake in IDLE the block SHALL latch cmd, dstaddr, srcaddr and data, clear beat counter and error accumulator, and go to ACC next cycle.
REQ-012 A request SHALL be legal iff opcode is READ, WRITE or POSTED, group match=1, 2^SIZE*8==RW, and LEN+1<=NREG.
REQ-013 Illegal READ/WRITE SHALL skip register access and go to RESP with ERR=2'b10, data 0; illegal POSTED or any other opcode SHALL be dropped with no response (back to IDLE).
REQ-014 ACC SHALL hold reg_valid=1, reg_addr=dstaddr[RAW-1:0]+beat*(RW/8) (modulo 2^RAW), reg_wdata=data lane beat, reg_prot=PROT, reg_write=1 for WRITE/POSTED and 0 for READ.
REQ-015 The register handshake SHALL complete when reg_valid&reg_ready; for writes, reg_err SHALL be OR-ed into the accumulator that cycle and beat SHALL increment.
REQ-016 A read handshake SHALL go to RDWAIT; reg_rvalid in RDWAIT SHALL store reg_rdata into resp_data lane beat, OR reg_err, increment beat and return to ACC. Read latency SHALL be unbounded, and reg_rvalid outside RDWAIT SHALL be ignored.
REQ-017 After beat LEN completes: POSTED SHALL go to IDLE; READ/WRITE SHALL go to RESP.
REQ-018 RESP SHALL assert udev_resp_valid with stable outputs until udev_resp_ready, then go to IDLE; the next request is accepted no earlier than the following cycle.
REQ-019 resp_cmd SHALL be: [4:0]=RESP_READ or RESP_WRITE; [26:25]=accumulated error; all other bits copied from the request cmd.
REQ-020 resp_dstaddr SHALL be req srcaddr and resp_srcaddr SHALL be req dstaddr.
REQ-021 resp_data lanes beyond LEN SHALL be 0; WRITE response data SHALL be 0.
REQ-022 Minimum latency, single-beat write with reg_ready=1: accept at cycle 0, register write at cycle 1, resp_valid at cycle 2.

Reset
REQ-023 While nreset=0: state=IDLE, udev_req_ready=0, udev_resp_valid=0, reg_valid=0, reg_write=0, beat=0, error accumulator=0; udev_req_ready SHALL go to 1 on the first clk edge after deassertion.
REQ-024 Reset mid-transaction SHALL abandon it with no response and no further register access; resp data/address registers need no reset.

Verification
REQ-025 Single write, cmd LEN=0, SIZE=2, addr 0x10, data 0xAABBCCDD, reg_ready=1 -> one reg write at 0x10 with data 0xAABBCCDD; response RESP_WRITE, ERR=00, in cycle 2.
REQ-026 Read with LEN=1 at 0x20, rdata 0x11111111 then 0x22222222 with reg_rvalid 3 cycles after each handshake -> reg reads at 0x20 and 0x24; resp_data=0x2222222211111111.
REQ-027 Posted write with LEN=1 -> two reg writes, no udev_resp_valid; write with reg_err=01 on beat 0 -> resp ERR=01.
REQ-028 Read with SIZE=3 (RW=32), or LEN=2 -> no reg_valid; response ERR=10, data 0; atomic 5'h09 -> no response.
REQ-029 Response held 5 cycles with resp_ready=0 -> outputs stable and udev_req_ready=0; nreset pulsed while in RDWAIT -> no response, IDLE after release.
REQ-030 GRPAW=8, GRPID=0x5A: dstaddr[31:24]=0x5A accepted normally; 0x5B read -> ERR=10 and no reg_valid.
